hysteresis_edge_tracker: RTL



---
 rtl/hysteresis_edge_tracker.sv | 139 +++++++++++++
 1 files changed

// File: rtl/hysteresis_edge_tracker.sv
// Canny hysteresis: promotes weak pixels 8-connected to strong ones and clears the rest, over NUM_PASSES raster scans of the interior.
// done rises 2+NUM_PASSES*(HEIGHT-2)*(WIDTH-2) edges after enable is sampled; Z is captured only in LOAD.
module hysteresis_edge_tracker #(
   parameter int         HEIGHT       = 5,
   parameter int         WIDTH        = 5,
   parameter logic [7:0] WEAK_PIXEL   = 8'd75,
   parameter logic [7:0] STRONG_PIXEL = 8'd255,
   parameter int         NUM_PASSES   = 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            enable,
   output logic                            done,
   input  logic [HEIGHT*WIDTH-1:0][7:0]    Z,
   output logic [HEIGHT*WIDTH-1:0][7:0]    res
);

   localparam int NPIX = HEIGHT * WIDTH;
   localparam int RW   = $clog2(HEIGHT);
   localparam int CW   = $clog2(WIDTH);
   localparam int PW   = $clog2(NUM_PASSES + 1);
   localparam int IW   = $clog2(NPIX);

   localparam logic [RW-1:0] LAST_ROW  = RW'(HEIGHT - 2);
   localparam logic [CW-1:0] LAST_COL  = CW'(WIDTH - 2);
   localparam logic [PW-1:0] LAST_PASS = PW'(NUM_PASSES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SCAN,
      S_WRITE,
      S_DONE
   } state_t;

   state_t state, state_next;

   logic [NPIX-1:0][7:0] work_buf;
   logic [RW-1:0]        row_cnt;
   logic [CW-1:0]        col_cnt;
   logic [PW-1:0]        pass_cnt;

   logic [IW-1:0]        cur_idx;
   logic [7:0]           cur_pix;
   logic                 strong_nbr;
   logic [7:0]           pix_next;
   logic                 row_end;
   logic                 frame_end;

   // Neighbour reads come straight from the working buffer, so promotions
   // written earlier in the same pass propagate forward immediately.
   always_comb begin
      int nidx;
      cur_idx    = IW'(int'(row_cnt) * WIDTH + int'(col_cnt));
      cur_pix    = work_buf[cur_idx];
      strong_nbr = 1'b0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            nidx = (int'(row_cnt) + dr) * WIDTH + int'(col_cnt) + dc;
            if ((dr != 0 || dc != 0) && work_buf[IW'(nidx)] == STRONG_PIXEL)
               strong_nbr = 1'b1;
         end
      end
   end

   always_comb begin
      pix_next = 8'd0;
      if (cur_pix == STRONG_PIXEL) begin
         pix_next = STRONG_PIXEL;
      end else if (cur_pix == WEAK_PIXEL) begin
         if (strong_nbr)
            pix_next = STRONG_PIXEL;
         else if (pass_cnt != LAST_PASS)
            pix_next = WEAK_PIXEL;
         else
            pix_next = 8'd0;
      end
   end

   assign row_end   = (col_cnt == LAST_COL);
   assign frame_end = row_end && (row_cnt == LAST_ROW);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (enable) state_next = S_LOAD;
         S_LOAD:  state_next = S_SCAN;
         S_SCAN:  if (frame_end && pass_cnt == LAST_PASS) state_next = S_WRITE;
         S_WRITE: state_next = S_DONE;
         S_DONE:  state_next = enable ? S_LOAD : S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         work_buf <= '0;
         res      <= '0;
         done     <= 1'b0;
         row_cnt  <= '0;
         col_cnt  <= '0;
         pass_cnt <= '0;
      end else begin
         done <= (state_next == S_DONE);
         case (state)
            S_LOAD: begin
               work_buf <= Z;
               row_cnt  <= RW'(1);
               col_cnt  <= CW'(1);
               pass_cnt <= '0;
            end
            S_SCAN: begin
               work_buf[cur_idx] <= pix_next;
               if (row_end) begin
                  col_cnt <= CW'(1);
                  if (frame_end) begin
                     row_cnt  <= RW'(1);
                     pass_cnt <= pass_cnt + PW'(1);
                  end else begin
                     row_cnt <= row_cnt + RW'(1);
                  end
               end else begin
                  col_cnt <= col_cnt + CW'(1);
               end
            end
            S_WRITE: res <= work_buf;
            default: ;
         endcase
      end
   end

endmodule
